// File: rtl/traffic_light_controller.sv
// traffic_light_controller
// ------------------------
// Fixed-time Moore controller for a T-junction with four signal heads:
// M1/M2 (main road, both directions), MT (main-road turn lane) and
// S (side road). A single dwell counter times each phase. The state
// register decodes directly to the lamp outputs.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  synchronous reset, active-high
//   light_M1  out  3  M1 head {red,yellow,green}
//   light_S   out  3  S head  {red,yellow,green}
//   light_MT  out  3  MT head {red,yellow,green}
//   light_M2  out  3  M2 head {red,yellow,green}
//
// Optional build macro ALL_RED_EN: adds an all-red clearance phase S7
// (T_CLR cycles). S7 is inserted between S4 and S5, and again between S6 and S1.
module traffic_light_controller #(
  parameter int unsigned T_MAIN = 32'd7,
  parameter int unsigned T_YEL  = 32'd2,
  parameter int unsigned T_TURN = 32'd5,
  parameter int unsigned T_SIDE = 32'd3,
  parameter int unsigned CNT_W  = 32'd4
`ifdef ALL_RED_EN
  ,
  parameter int unsigned T_CLR  = 32'd1
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
`ifdef ALL_RED_EN
    ,
    S7 = 3'd6
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_s;
  logic             legal_s;
  state_e           next_s;
`ifdef ALL_RED_EN
  // Set when leaving S6, so the clearance phase S7 knows to exit towards S1 and not S5.
  logic             ret_main_q, ret_main_d;
`endif

  // Dwell length and successor of the current phase.
  always_comb begin
    dur_s   = CNT_ONE;
    next_s  = S1;
    legal_s = 1'b1;
    case (state_q)
      S1: begin dur_s = CNT_W'(T_MAIN); next_s = S2; end
      S2: begin dur_s = CNT_W'(T_YEL);  next_s = S3; end
      S3: begin dur_s = CNT_W'(T_TURN); next_s = S4; end
`ifdef ALL_RED_EN
      S4: begin dur_s = CNT_W'(T_YEL);  next_s = S7; end
      S5: begin dur_s = CNT_W'(T_SIDE); next_s = S6; end
      S6: begin dur_s = CNT_W'(T_YEL);  next_s = S7; end
      S7: begin
        dur_s  = CNT_W'(T_CLR);
        next_s = ret_main_q ? S1 : S5;
      end
`else
      S4: begin dur_s = CNT_W'(T_YEL);  next_s = S5; end
      S5: begin dur_s = CNT_W'(T_SIDE); next_s = S6; end
      S6: begin dur_s = CNT_W'(T_YEL);  next_s = S1; end
`endif
      default: begin dur_s = CNT_ONE; next_s = S1; legal_s = 1'b0; end
    endcase
  end

  // Next-state and counter update; an unused encoding recovers to S1 on the next edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ALL_RED_EN
    ret_main_d = ret_main_q;
`endif
    if (rst || !legal_s) begin
      state_d = S1;
      cnt_d   = CNT_ZERO;
`ifdef ALL_RED_EN
      ret_main_d = 1'b0;
`endif
    end else if (cnt_q == (dur_s - CNT_ONE)) begin
      state_d = next_s;
      cnt_d   = CNT_ZERO;
`ifdef ALL_RED_EN
      if (state_q == S6) begin
        ret_main_d = 1'b1;
      end else if (state_q == S7) begin
        ret_main_d = 1'b0;
      end else begin
        ret_main_d = ret_main_q;
      end
`endif
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, dwell counter and return flag registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
`ifdef ALL_RED_EN
    ret_main_q <= ret_main_d;
`endif
  end

  // Moore decode of the state register; unused encodings show all red.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state_q)
      S1: begin light_M1 = GRN; light_M2 = GRN; end
      S2: begin light_M1 = GRN; light_M2 = YEL; end
      S3: begin light_M1 = GRN; light_MT = GRN; end
      S4: begin light_M1 = YEL; light_MT = YEL; end
      S5: begin light_S  = GRN; end
      S6: begin light_S  = YEL; end
      default: begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed testbench for traffic_light_controller. It runs a default-timed
// instance and an instance with every phase one cycle long. The expected
// phase for each edge comes from a hand-written schedule table.
module tb_traffic_light_controller;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

`ifdef ALL_RED_EN
  localparam int NPH = 8;
  localparam int SEQ [NPH] = '{1, 2, 3, 4, 7, 5, 6, 7};
  localparam int DUR [NPH] = '{7, 2, 5, 2, 1, 3, 2, 1};
`else
  localparam int NPH = 6;
  localparam int SEQ [NPH] = '{1, 2, 3, 4, 5, 6};
  localparam int DUR [NPH] = '{7, 2, 5, 2, 3, 2};
`endif

  logic       clk;
  logic       rst;
  logic [2:0] m1, m2, mt, s;
  logic [2:0] f_m1, f_m2, f_mt, f_s;

  int n_checks;
  int n_pass;
  int k;

  traffic_light_controller dut (
    .clk(clk), .rst(rst),
    .light_M1(m1), .light_S(s), .light_MT(mt), .light_M2(m2)
  );

  traffic_light_controller #(
    .T_MAIN(1), .T_YEL(1), .T_TURN(1), .T_SIDE(1)
  ) dut_fast (
    .clk(clk), .rst(rst),
    .light_M1(f_m1), .light_S(f_s), .light_MT(f_mt), .light_M2(f_m2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  // Lamp pattern {M1,M2,MT,S} of each phase.
  function automatic logic [11:0] pattern_of(input int ph);
    case (ph)
      1: return {GRN, GRN, RED, RED};
      2: return {GRN, YEL, RED, RED};
      3: return {GRN, RED, GRN, RED};
      4: return {YEL, RED, YEL, RED};
      5: return {RED, RED, RED, GRN};
      6: return {RED, RED, RED, YEL};
      default: return {RED, RED, RED, RED};
    endcase
  endfunction

  // Phase expected after k non-reset edges since the last reset edge.
  function automatic int phase_at(input int kk, input bit fast);
    int per, r, d;
    per = 0;
    for (int i = 0; i < NPH; i++) per += fast ? 1 : DUR[i];
    r = kk % per;
    for (int i = 0; i < NPH; i++) begin
      d = fast ? 1 : DUR[i];
      if (r < d) return SEQ[i];
      r -= d;
    end
    return 0;
  endfunction

  function automatic bit legal_code(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  function automatic bit safe(input logic [11:0] p);
    bit mnr, snr;
    mnr = (p[11:9] != RED) || (p[8:6] != RED) || (p[5:3] != RED);
    snr = (p[2:0] != RED);
    return !(mnr && snr) && !((p[8:6] != RED) && (p[5:3] != RED))
           && legal_code(p[11:9]) && legal_code(p[8:6])
           && legal_code(p[5:3]) && legal_code(p[2:0]);
  endfunction

  task automatic check_cycle(input string tag);
    logic [11:0] pd, pf;
    pd = {m1, m2, mt, s};
    pf = {f_m1, f_m2, f_mt, f_s};
    check({tag, "_main"}, pd, pattern_of(phase_at(k, 1'b0)));
    check({tag, "_fast"}, pf, pattern_of(phase_at(k, 1'b1)));
    check({tag, "_safe"}, {11'd0, safe(pd)}, 12'd1);
    check({tag, "_safe_fast"}, {11'd0, safe(pf)}, 12'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    k        = 0;
    rst      = 1'b1;

    // Two reset edges; the block must sit in S1 after each.
    @(posedge clk); #1;
    check("rst_edge1", {m1, m2, mt, s}, {GRN, GRN, RED, RED});
    check("rst_edge1_fast", {f_m1, f_m2, f_mt, f_s}, {GRN, GRN, RED, RED});
    @(posedge clk); #1;
    check("rst_edge2", {m1, m2, mt, s}, {GRN, GRN, RED, RED});
    rst = 1'b0;
    k   = 0;

    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 17) k = 0;
      else         k++;
      check_cycle($sformatf("edge%0d", n));
`ifndef ALL_RED_EN
      if (n == 6)  check("m2_green_e6", {9'd0, m2}, {9'd0, GRN});
      if (n == 7)  check("m2_yel_e7",   {9'd0, m2}, {9'd0, YEL});
      if (n == 9)  check("e9_mt_m2",    {6'd0, mt, m2}, {6'd0, GRN, RED});
      if (n == 16) check("e16_s_m1",    {6'd0, s, m1}, {6'd0, GRN, RED});
`else
      if (n == 16) check("e16_all_red", {m1, m2, mt, s}, {RED, RED, RED, RED});
`endif
      if (n == 17) check("rst_mid_s1", {m1, m2, mt, s}, {GRN, GRN, RED, RED});
      if (n == 16) rst = 1'b1;
      if (n == 17) rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
Fixed-time Moore controller for a T-junction. It drives four signal heads:
- M1: main road, direction 1
- M2: main road, direction 2
- MT: main-road turn lane
- S: side road

It cycles through six timed phases using one dwell counter. It is a standalone leaf block clocked by the system clock, with no inputs other than clock and reset.

Parameters:
T_MAIN, 7, cycles in S1 (M1+M2 green)
T_YEL, 2, cycles in every yellow phase (S2, S4, S6)
T_TURN, 5, cycles in S3 (M1+MT green)
T_SIDE, 3, cycles in S5 (S green)
CNT_W, 4, dwell counter width; every T_* must be in 1..2^CNT_W-1

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  synchronous reset, active-high
light_M1  out  3  M1 head, {red,yellow,green}
light_S   out  3  S head, {red,yellow,green}
light_MT  out  3  MT head, {red,yellow,green}
light_M2  out  3  M2 head, {red,yellow,green}

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Light encoding is one-hot: RED=3'b100, YEL=3'b010, GRN=3'b001. No other code is ever driven.
- Registers: a 3-bit state register and a CNT_W-bit counter. There is no other storage.
- Outputs are a pure combinational decode of the state register (Moore). They change only after a clock edge.
- Reset: on a rising edge with rst=1, state<=S1 and count<=0.
  - Outputs after that edge: M1=GRN, M2=GRN, MT=RED, S=RED.
  - rst held high keeps the block frozen in S1 with count 0.
  - Reset asserted mid-phase aborts the phase at the next edge.
- Counting: on each edge with rst=0, if count==DUR(state)-1 then state<=next and count<=0; otherwise count<=count+1.
  - Each phase therefore lasts exactly DUR clock cycles.
  - DUR=1 gives a one-cycle phase.
- Phase table (state: M1 M2 MT S, DUR, next):
  - S1: GRN GRN RED RED, T_MAIN, S2
  - S2: GRN YEL RED RED, T_YEL, S3
  - S3: GRN RED GRN RED, T_TURN, S4
  - S4: YEL RED YEL RED, T_YEL, S5
  - S5: RED RED RED GRN, T_SIDE, S6
  - S6: RED RED RED YEL, T_YEL, S1
- Full period is T_MAIN+T_TURN+T_SIDE+3*T_YEL cycles, which is 21 with the defaults.
- Safety invariants, checked every cycle:
  - S is never non-RED while any of M1, M2 or MT is non-RED.
  - M2 and MT are never both non-RED.
- Unused state encodings: the next edge goes to S1 with count 0. While in an unused encoding, the outputs decode to all RED.
- The counter never wraps. Values at or above DUR cannot occur from legal states.

Optional Feature:
Macro ALL_RED_EN.
- When defined, add parameter T_CLR (default 1) and state S7 (all four heads RED, DUR=T_CLR).
- S4 then goes to S7, and S7 goes to S5.
- S6 goes to a second visit of S7, whose exit goes to S1. Track this with a 1-bit "returning to main" flag, set on S6 exit and cleared on S7 exit.
- With the defaults, the period becomes 23 cycles.
- When undefined: S7, T_CLR and the flag do not exist, and the transitions are exactly the six-phase table above.

Test Plan:
- Hold rst=1 for 2 edges, release. Required: M1=001, M2=001, MT=100, S=100 for 7 cycles counted from the last reset edge. M2 becomes 010 after non-reset edge 7.
- Run 100 cycles with 10 ns period after release. Phase boundaries fall on non-reset edges 7, 9, 14, 16, 19, 21 (S2, S3, S4, S5, S6, S1), repeating every 21 edges. At edge 9, MT=001 and M2=100. At edge 16, S=001 and M1=100.
- Assert rst for 1 edge at non-reset edge 17 (in S5). Required: after that edge, S1 pattern with a full 7-cycle dwell.
- Every cycle, check the safety invariants and that each output is exactly one of 100, 010 or 001.
- Use parameter override T_MAIN=1, T_TURN=1, T_SIDE=1, T_YEL=1. Required: phase changes on every edge, period 6.
- With ALL_RED_EN defined: all four heads read 100 for 1 cycle between S4 and S5 and between S6 and S1. Period is 23.
